// File: rtl/data_sync.sv
// data_sync: enable-qualified multi-bit CDC receiver with a valid/ack handshake,
// a sticky overrun flag and a wrapping captured-word counter.
module data_sync #(
  parameter int NUM_STAGES  = 2,
  parameter int BUS_WIDTH   = 8,
  parameter int TOGGLE_MODE = 0,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 BUS_ENABLE,
  input  logic                 DATA_ACK,
  input  logic                 OVERRUN_CLR,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 ENABLE_PULSE,
  output logic                 DATA_VALID,
  output logic                 OVERRUN,
  output logic [CNT_WIDTH-1:0] WORD_CNT
);
  logic [NUM_STAGES-1:0] sync_q, sync_d;
  logic                  en_d_q, en_s, evt;
  logic [BUS_WIDTH-1:0]  bus_q, bus_d;
  logic                  pulse_q, valid_q, valid_d, ovr_q, ovr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  always_comb begin
    sync_d  = {sync_q[NUM_STAGES-2:0], BUS_ENABLE};
    en_s    = sync_q[NUM_STAGES-1];
    evt     = (TOGGLE_MODE != 0) ? (en_s ^ en_d_q) : (en_s & ~en_d_q);
    bus_d   = evt ? UNSYNC_BUS : bus_q;
    cnt_d   = evt ? cnt_q + 1'b1 : cnt_q;
    valid_d = evt | (valid_q & ~DATA_ACK);
    // an ack landing on the capture edge consumes the old word, so no overrun
    ovr_d   = (evt & valid_q & ~DATA_ACK) | (ovr_q & ~OVERRUN_CLR);
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q  <= '0;
      en_d_q  <= 1'b0;
      bus_q   <= '0;
      pulse_q <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      en_d_q  <= en_s;
      bus_q   <= bus_d;
      pulse_q <= evt;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end
  assign SYNC_BUS     = bus_q;
  assign ENABLE_PULSE = pulse_q;
  assign DATA_VALID   = valid_q;
  assign OVERRUN      = ovr_q;
  assign WORD_CNT     = cnt_q;
endmodule

// File: tb/tb_data_sync.sv
// tb_data_sync: level-mode and toggle-mode receivers driven with shared stimulus,
// checked against directed vectors and a cycle-level reference model.
module tb_data_sync;
  localparam int NS = 2;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] data = '0;
  logic       en = 1'b0, ack = 1'b0, clr = 1'b0;
  logic [7:0] sbus [2];
  logic       pulse [2], valid [2], ovr [2];
  logic [7:0] cnt [2];
  int n_tests = 0, n_fail = 0;

  always #5 CLK = ~CLK;

  data_sync #(.NUM_STAGES(NS), .BUS_WIDTH(8), .TOGGLE_MODE(0), .CNT_WIDTH(8)) u_lvl (
    .CLK(CLK), .RST(RST), .UNSYNC_BUS(data), .BUS_ENABLE(en), .DATA_ACK(ack), .OVERRUN_CLR(clr),
    .SYNC_BUS(sbus[0]), .ENABLE_PULSE(pulse[0]), .DATA_VALID(valid[0]), .OVERRUN(ovr[0]), .WORD_CNT(cnt[0]));
  data_sync #(.NUM_STAGES(NS), .BUS_WIDTH(8), .TOGGLE_MODE(1), .CNT_WIDTH(8)) u_tgl (
    .CLK(CLK), .RST(RST), .UNSYNC_BUS(data), .BUS_ENABLE(en), .DATA_ACK(ack), .OVERRUN_CLR(clr),
    .SYNC_BUS(sbus[1]), .ENABLE_PULSE(pulse[1]), .DATA_VALID(valid[1]), .OVERRUN(ovr[1]), .WORD_CNT(cnt[1]));

  // Reference: the event seen at an edge is decided by the enable samples taken
  // NS and NS+1 edges earlier; hist[0] is the older, hist[1] the newer of those.
  bit         hist [0:NS];
  logic [7:0] m_bus [2], m_cnt [2];
  bit         m_pulse [2], m_valid [2], m_ovr [2];

  function automatic bit ev_of(int m);
    return (m == 1) ? (hist[1] != hist[0]) : (hist[1] && !hist[0]);
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i <= NS; i++) hist[i] <= 1'b0;
      for (int m = 0; m < 2; m++) begin
        m_bus[m] <= '0; m_cnt[m] <= '0; m_pulse[m] <= 1'b0; m_valid[m] <= 1'b0; m_ovr[m] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NS; i++) hist[i] <= hist[i+1];
      hist[NS] <= en;
      for (int m = 0; m < 2; m++) begin
        m_pulse[m] <= ev_of(m);
        if (ev_of(m)) begin
          m_bus[m]   <= data;
          m_cnt[m]   <= m_cnt[m] + 8'd1;
          m_valid[m] <= 1'b1;
          if (m_valid[m] && !ack) m_ovr[m] <= 1'b1;
          else if (clr) m_ovr[m] <= 1'b0;
        end else begin
          if (ack) m_valid[m] <= 1'b0;
          if (clr) m_ovr[m] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_model();
    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if ({sbus[m], pulse[m], valid[m], ovr[m], cnt[m]} !==
          {m_bus[m], m_pulse[m], m_valid[m], m_ovr[m], m_cnt[m]}) begin
        n_fail++;
        $display("FAIL model%0d t=%0t got bus=%h p=%b v=%b o=%b c=%0d exp bus=%h p=%b v=%b o=%b c=%0d",
                 m, $time, sbus[m], pulse[m], valid[m], ovr[m], cnt[m],
                 m_bus[m], m_pulse[m], m_valid[m], m_ovr[m], m_cnt[m]);
      end
    end
  endtask

  task automatic cyc(bit e, logic [7:0] d, bit a, bit c);
    en = e; data = d; ack = a; clr = c;
    @(posedge CLK); #1;
    chk_model();
  endtask

  task automatic do_reset();
    en = 0; data = 0; ack = 0; clr = 0; RST = 0;
    repeat (2) @(posedge CLK);
    #1 RST = 1;
  endtask

  typedef struct {
    bit en; logic [7:0] d; bit ack; bit clr;
    bit p; logic [7:0] bus; bit v; logic [7:0] c; bit o;
  } vec_t;
  vec_t tbl [34];

  function automatic vec_t mk(bit e, logic [7:0] d, bit a, bit c, bit p, logic [7:0] b, bit v, logic [7:0] n, bit o);
    vec_t r;
    r.en = e; r.d = d; r.ack = a; r.clr = c; r.p = p; r.bus = b; r.v = v; r.c = n; r.o = o;
    return r;
  endfunction

  initial begin
    int first_p, second_p, n_p, hold;
    logic [7:0] first_bus;
    for (int i = 0; i < 2; i++)   tbl[i] = mk(1, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 0);
    tbl[2] = mk(1, 8'hA5, 0, 0, 1, 8'hA5, 1, 1, 0);
    for (int i = 3; i < 10; i++)  tbl[i] = mk(1, 8'hA5, 0, 0, 0, 8'hA5, 1, 1, 0);
    tbl[10] = mk(0, 8'hA5, 1, 0, 0, 8'hA5, 0, 1, 0);
    for (int i = 11; i < 14; i++) tbl[i] = mk(0, 8'hA5, 0, 0, 0, 8'hA5, 0, 1, 0);
    for (int i = 14; i < 16; i++) tbl[i] = mk(1, 8'h3C, 0, 0, 0, 8'hA5, 0, 1, 0);
    tbl[16] = mk(1, 8'h3C, 0, 0, 1, 8'h3C, 1, 2, 0);
    tbl[17] = mk(1, 8'h3C, 0, 0, 0, 8'h3C, 1, 2, 0);
    for (int i = 18; i < 22; i++) tbl[i] = mk(0, 8'h3C, 0, 0, 0, 8'h3C, 1, 2, 0);
    for (int i = 22; i < 24; i++) tbl[i] = mk(1, 8'hC3, 0, 0, 0, 8'h3C, 1, 2, 0);
    tbl[24] = mk(1, 8'hC3, 0, 0, 1, 8'hC3, 1, 3, 1);
    tbl[25] = mk(1, 8'hC3, 0, 1, 0, 8'hC3, 1, 3, 0);
    for (int i = 26; i < 29; i++) tbl[i] = mk(0, 8'hC3, 0, 0, 0, 8'hC3, 1, 3, 0);
    for (int i = 29; i < 31; i++) tbl[i] = mk(1, 8'h5A, 0, 0, 0, 8'hC3, 1, 3, 0);
    tbl[31] = mk(1, 8'h5A, 1, 0, 1, 8'h5A, 1, 4, 0);
    tbl[32] = mk(1, 8'h5A, 0, 0, 0, 8'h5A, 1, 4, 0);
    tbl[33] = mk(0, 8'h5A, 1, 0, 0, 8'h5A, 0, 4, 0);

    do_reset();
    chk("reset_lvl", {sbus[0], pulse[0], valid[0], ovr[0], cnt[0]}, '0);
    chk("reset_tgl", {sbus[1], pulse[1], valid[1], ovr[1], cnt[1]}, '0);

    // level-mode directed sequence: capture, hold, overrun, clear, ack-on-event
    for (int i = 0; i < 34; i++) begin
      cyc(tbl[i].en, tbl[i].d, tbl[i].ack, tbl[i].clr);
      chk($sformatf("vec%0d", i), {sbus[0], pulse[0], valid[0], cnt[0], ovr[0]},
          {tbl[i].bus, tbl[i].p, tbl[i].v, tbl[i].c, tbl[i].o});
    end

    // toggle mode: 0->1->0 with 6-cycle spacing
    do_reset();
    first_p = -1; second_p = -1; n_p = 0; first_bus = '0;
    for (int i = 0; i < 16; i++) begin
      cyc(i < 6, (i < 6) ? 8'h11 : 8'h22, 0, 0);
      if (pulse[1]) begin
        n_p++;
        if (first_p < 0) begin first_p = i; first_bus = sbus[1]; end
        else second_p = i;
      end
    end
    chk("tgl_npulse", n_p, 2);
    chk("tgl_first_at", first_p, 2);
    chk("tgl_first_bus", first_bus, 8'h11);
    chk("tgl_spacing", second_p - first_p, 6);
    chk("tgl_bus", sbus[1], 8'h22);
    chk("tgl_cnt", cnt[1], 2);

    // 256 acknowledged words: counter wraps, no overrun
    do_reset();
    for (int w = 0; w < 256; w++) begin
      if (w == 255) chk("cnt_255", cnt[0], 255);
      for (int k = 0; k < 8; k++) cyc(k < 4, w[7:0], 1, 0);
    end
    chk("wrap_cnt", cnt[0], 0);
    chk("wrap_ovr", ovr[0], 0);
    chk("wrap_bus", sbus[0], 8'hFF);

    // reset while an enable is in the synchronizer
    cyc(1, 8'h77, 0, 0);
    RST = 0; #1;
    chk("rst_mid_lvl", {sbus[0], pulse[0], valid[0], ovr[0], cnt[0]}, '0);
    chk("rst_mid_tgl", {sbus[1], pulse[1], valid[1], ovr[1], cnt[1]}, '0);
    repeat (2) @(posedge CLK);
    #1 RST = 1;
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 8'h77, 0, 0);
      chk($sformatf("rst_rel_lvl_e%0d", i), pulse[0], i == 3);
      chk($sformatf("rst_rel_tgl_e%0d", i), pulse[1], i == 3);
    end
    chk("rst_rel_bus", sbus[0], 8'h77);

    // randomized traffic against the reference model
    do_reset();
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin en = ~en; hold = $urandom_range(1, 6); end
      hold--;
      cyc(en, 8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
